conv1_k_mem_write: RTL and testbench

Loader that fills the Convolution 1 kernel weight memory before inference. It accepts weight pairs from the host-side register/streaming interface over a valid/ready handshake and issues registered dual-port writes: the low half goes to addresses 0..KSIZE-1 and the high half to KSIZE..2*KSIZE-1, which is the same split the conv1 weight read counter walks. It asserts `done` once every word has been committed, and the layer controller gates the read counter's `enable` on that signal.

---
 rtl/conv1_k_mem_write_if.sv | 26 ++
 rtl/conv1_k_mem_write.sv | 100 ++++++++++
 tb/tb_conv1_k_mem_write.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/conv1_k_mem_write_if.sv
// Weight-pair stream into the conv1 kernel loader and its dual-port write bus.
// master = host/memory side, slave = loader.
interface conv1_k_mem_write_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;

    modport master (
        output in_valid, in_data0, in_data1,
        input  in_ready, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
    );

    modport slave (
        input  in_valid, in_data0, in_data1,
        output in_ready, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
    );
endinterface

// File: rtl/conv1_k_mem_write.sv
// Conv1 kernel weight loader: accepts KSIZE weight pairs and writes them to both memory halves.
// Optional running checksum of written words when CONV1_K_WRITE_CHECKSUM_EN is defined.
module conv1_k_mem_write #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int KSIZE  = 25
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    conv1_k_mem_write_if.slave      bus,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W+6:0]       checksum
);
    localparam int CSUM_W = DATA_W + 7;
    localparam logic [ADDR_W-1:0] KSIZE_A = ADDR_W'(KSIZE);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(KSIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, LAST, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              cnt_last;

    assign accept   = bus.in_valid & bus.in_ready;
    assign cnt_last = (cnt == LAST_A);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // start restarts from any state; in LOAD it also masks in_ready so no beat is lost
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                if (start)                    state_nx = LOAD;
                else if (accept && cnt_last)  state_nx = LAST;
            end
            LAST: state_nx = start ? LOAD : DONE;
            DONE: if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            LOAD: begin
                bus.in_ready = ~start;
                busy         = 1'b1;
            end
            LAST: busy = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cnt <= '0;
        else if (start)  cnt <= '0;
        else if (accept) cnt <= cnt_last ? '0 : cnt + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_en    <= 1'b0;
            bus.wr_addr0 <= '0;
            bus.wr_addr1 <= '0;
            bus.wr_data0 <= '0;
            bus.wr_data1 <= '0;
        end else begin
            bus.wr_en <= accept;
            if (accept) begin
                bus.wr_addr0 <= cnt;
                bus.wr_addr1 <= cnt + KSIZE_A;
                bus.wr_data0 <= bus.in_data0;
                bus.wr_data1 <= bus.in_data1;
            end
        end
    end

`ifdef CONV1_K_WRITE_CHECKSUM_EN
    // a write still in flight when start arrives belongs to the abandoned load
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          checksum <= '0;
        else if (start)     checksum <= '0;
        else if (bus.wr_en) checksum <= checksum + CSUM_W'(bus.wr_data0) + CSUM_W'(bus.wr_data1);
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_conv1_k_mem_write.sv
// Randomized bench for conv1_k_mem_write against a beat-level load model.
module tb_conv1_k_mem_write;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int KSIZE  = 25;
    localparam int CSUM_W = DATA_W + 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    conv1_k_mem_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    conv1_k_mem_write #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .KSIZE(KSIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // load model: a load is active from start until its KSIZE-th write has been presented
    bit m_active, m_done, m_wr_en;
    int m_k, m_last_beat, m_a0, m_a1, m_d0, m_d1, m_csum;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_wr_en = 0; m_k = 0; m_last_beat = 0;
        m_a0 = 0; m_a1 = 0; m_d0 = 0; m_d1 = 0; m_csum = 0;
    endtask

    function automatic int exp_csum();
`ifdef CONV1_K_WRITE_CHECKSUM_EN
        return m_csum;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs(input string sfx);
        check({"wr_en", sfx},    bus.wr_en,    m_wr_en);
        check({"wr_addr0", sfx}, bus.wr_addr0, m_a0);
        check({"wr_addr1", sfx}, bus.wr_addr1, m_a1);
        check({"wr_data0", sfx}, bus.wr_data0, m_d0);
        check({"wr_data1", sfx}, bus.wr_data1, m_d1);
        check({"busy", sfx},     busy,         m_active);
        check({"done", sfx},     done,         m_done);
        check({"checksum", sfx}, checksum,     exp_csum());
    endtask

    // inputs already driven; checks in_ready, clocks once, then checks registered outputs
    task automatic cycle(output bit acc);
        bit exp_ready, fin;
        #1;
        exp_ready = m_active && (m_k < KSIZE) && !start;
        check("in_ready", bus.in_ready, exp_ready);
        acc = exp_ready && bus.in_valid;
        fin = m_wr_en && (m_last_beat == KSIZE - 1);
        if (start) begin
            m_csum = 0; m_done = 0; m_active = 1; m_k = 0;
        end else begin
            if (m_wr_en) m_csum = m_csum + m_d0 + m_d1;
            if (fin) begin m_done = 1; m_active = 0; end
        end
        m_wr_en = acc;
        if (acc) begin
            m_a0 = m_k; m_a1 = m_k + KSIZE;
            m_d0 = bus.in_data0; m_d1 = bus.in_data1;
            m_last_beat = m_k;
            m_k++;
        end
        @(posedge clk);
        #1;
        check_outputs("");
        if (bus.wr_en) pulses++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("in_ready_rst", bus.in_ready, 0);
        check_outputs("_rst");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_load(input int gap_pct, input int abort_at, input int reset_at, input bit ramp);
        bit acc, pending, aborted;
        int idx;
        aborted = 0; pending = 0; idx = 0; pulses = 0;
        start = 1'b1;
        bus.in_valid = 1'b0;
        cycle(acc);
        start = 1'b0;
        for (int c = 0; c < 1000 && !m_done; c++) begin
            if (!pending) begin
                bus.in_data0 = ramp ? DATA_W'(idx)       : DATA_W'($urandom);
                bus.in_data1 = ramp ? DATA_W'(100 + idx) : DATA_W'($urandom);
                pending = 1;
            end
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            if (reset_at >= 0 && m_k == reset_at) begin
                do_reset();
                return;
            end
            if (abort_at >= 0 && !aborted && m_k == abort_at) begin
                start = 1'b1;
                bus.in_valid = 1'b1;
                aborted = 1;
                pulses = 0;
            end
            cycle(acc);
            start = 1'b0;
            if (acc) begin pending = 0; idx++; end
        end
        check("done_reached", done, 1);
        check("pulse_count", pulses, KSIZE);
        bus.in_valid = 1'b1;
        repeat (3) cycle(acc);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data0 = '0;
        bus.in_data1 = '0;
        model_reset();
        #12;
        check("in_ready_init", bus.in_ready, 0);
        check_outputs("_init");
        @(negedge clk);
        reset = 1'b0;

        run_load(0, -1, -1, 1);
`ifdef CONV1_K_WRITE_CHECKSUM_EN
        check("csum_basic", checksum, 3100);
`else
        check("csum_basic", checksum, 0);
`endif
        run_load(40, -1, -1, 0);
        run_load(60, -1, -1, 0);
        run_load(0, 10, -1, 0);
        run_load(30, 10, -1, 0);
        run_load(0, -1, 12, 0);
        run_load(20, -1, -1, 0);
        run_load(0, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
